sap_controller: RTL and testbench

- Controller-sequencer for the SAP-1 datapath.
- Its ring counter walks T1..T6 and decodes the instruction-register opcode into the 12-bit control word.
- The control word drives the active-low load enables (lm_n, li_n, la_n, lb_n, lo_n) and the bus output enables of every datapath register.
- The state advances on the falling edge of clk, so each control word is stable at the rising edge where the registers sample.

---
 rtl/sap_controller.sv | 100 ++++++++++
 tb/tb_sap_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sap_controller.sv
// SAP-1 controller-sequencer: a six-state one-hot ring counter clocked on the falling
// edge. The T-state and opcode are decoded into the 12-bit control word.
module sap_controller (
  input  logic        clk,
  input  logic        async_reset,
  input  logic [3:0]  opcode,
  output logic [11:0] con,
  output logic [5:0]  t_state,
  output logic        hlt
);

  // con = {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n}
  localparam logic [11:0] CON_IDLE   = 12'h3E3;
  localparam logic [11:0] CON_T1     = 12'h5E3;
  localparam logic [11:0] CON_T2     = 12'hBE3;
  localparam logic [11:0] CON_T3     = 12'h263;
  localparam logic [11:0] CON_ADDR   = 12'h1A3;
  localparam logic [11:0] CON_LDA_T5 = 12'h2C3;
  localparam logic [11:0] CON_LDB_T5 = 12'h2E1;
  localparam logic [11:0] CON_ADD_T6 = 12'h3C7;
  localparam logic [11:0] CON_SUB_T6 = 12'h3CF;
  localparam logic [11:0] CON_OUT_T4 = 12'h3F2;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } state_t;

  state_t state_q;
  logic   halted_q;

  // Falling-edge update keeps the control word settled for the rising edge
  // at which the datapath registers sample.
  always_ff @(negedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else if (!halted_q) begin
      case (state_q)
        T1: state_q <= T2;
        T2: state_q <= T3;
        T3: state_q <= T4;
        T4: begin
          if (opcode == OP_HLT) halted_q <= 1'b1;
          else                  state_q  <= T5;
        end
        T5: state_q <= T6;
        T6: state_q <= T1;
        default: state_q <= T1; // any non-one-hot encoding recovers to T1
      endcase
    end
  end

  assign t_state = state_q;
  assign hlt     = halted_q | ((state_q == T4) && (opcode == OP_HLT));

  always_comb begin
    con = CON_IDLE;
    if (!halted_q) begin
      case (state_q)
        T1: con = CON_T1;
        T2: con = CON_T2;
        T3: con = CON_T3;
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: con = CON_ADDR;
            OP_OUT:                 con = CON_OUT_T4;
            default:                con = CON_IDLE;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA:         con = CON_LDA_T5;
            OP_ADD, OP_SUB: con = CON_LDB_T5;
            default:        con = CON_IDLE;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD:  con = CON_ADD_T6;
            OP_SUB:  con = CON_SUB_T6;
            default: con = CON_IDLE;
          endcase
        end
        default: con = CON_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_controller.sv
// Bench for sap_controller: directed instruction vectors, a halt and reset sequence,
// and random opcodes checked against a step-index model of the SAP-1 sequencer.
module tb_sap_controller;

  logic        clk;
  logic        async_reset;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic [5:0]  t_state;
  logic        hlt;

  int checks;
  int errors;

  sap_controller dut (
    .clk         (clk),
    .async_reset (async_reset),
    .opcode      (opcode),
    .con         (con),
    .t_state     (t_state),
    .hlt         (hlt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, actual running required finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [11:0] con;
    logic [5:0]  t;
    logic        hlt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: instruction step index 0..5 (T1..T6), plus a halted flag
  logic [11:0] fetch_tab [3];
  logic [11:0] exec_tab  [16][3];
  int          m_idx;
  bit          m_halted;

  function automatic logic [11:0] model_con(int idx, logic [3:0] op, bit halted);
    if (halted)   return 12'h3E3;
    if (idx < 3)  return fetch_tab[idx];
    return exec_tab[op][idx-3];
  endfunction

  function automatic logic model_hlt(int idx, logic [3:0] op, bit halted);
    return halted || (idx == 3 && op == 4'hF);
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic add_instr(input logic [3:0] fetch_op, input logic [3:0] op,
                           input logic [11:0] c4, input logic [11:0] c5,
                           input logic [11:0] c6, input int n);
    logic [11:0] cw [6];
    cw[0] = 12'h5E3; cw[1] = 12'hBE3; cw[2] = 12'h263;
    cw[3] = c4;      cw[4] = c5;      cw[5] = c6;
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.op  = (i == 0) ? fetch_op : op;
      v.con = cw[i];
      v.t   = 6'(1 << i);
      v.hlt = (op == 4'hF && i == 3);
      vecs.push_back(v);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_t_state"}, {6'd0, t_state}, {6'd0, 6'(1 << m_idx)});
    check({tag, "_con"}, con, model_con(m_idx, opcode, m_halted));
    check({tag, "_hlt"}, {11'd0, hlt}, {11'd0, model_hlt(m_idx, opcode, m_halted)});
  endtask

  initial begin
    logic [3:0] op;
    int halted_cycles;
    checks = 0;
    errors = 0;

    fetch_tab[0] = 12'h5E3; fetch_tab[1] = 12'hBE3; fetch_tab[2] = 12'h263;
    for (int o = 0; o < 16; o++)
      for (int s = 0; s < 3; s++) exec_tab[o][s] = 12'h3E3;
    exec_tab[0]  = '{12'h1A3, 12'h2C3, 12'h3E3};
    exec_tab[1]  = '{12'h1A3, 12'h2E1, 12'h3C7};
    exec_tab[2]  = '{12'h1A3, 12'h2E1, 12'h3CF};
    exec_tab[14] = '{12'h3F2, 12'h3E3, 12'h3E3};

    add_instr(4'h0, 4'h0, 12'h1A3, 12'h2C3, 12'h3E3, 6); // LDA
    add_instr(4'h1, 4'h1, 12'h1A3, 12'h2E1, 12'h3C7, 6); // ADD
    add_instr(4'h7, 4'h2, 12'h1A3, 12'h2E1, 12'h3CF, 6); // SUB, junk opcode at T1
    add_instr(4'hE, 4'hE, 12'h3F2, 12'h3E3, 12'h3E3, 6); // OUT
    add_instr(4'h5, 4'h5, 12'h3E3, 12'h3E3, 12'h3E3, 6); // NOP
    add_instr(4'hF, 4'hF, 12'h3E3, 12'h3E3, 12'h3E3, 4); // HLT up to T4

    async_reset = 1'b1;
    opcode      = 4'h0;
    #23;
    check("reset_t_state", {6'd0, t_state}, 12'h001);
    check("reset_con", con, 12'h5E3);
    check("reset_hlt", {11'd0, hlt}, 12'h000);

    @(negedge clk); #1;
    async_reset = 1'b0;
    #1;

    // directed instruction vectors
    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      #1;
      check($sformatf("vec%0d_t_state", i), {6'd0, t_state}, {6'd0, vecs[i].t});
      check($sformatf("vec%0d_con", i), con, vecs[i].con);
      check($sformatf("vec%0d_hlt", i), {11'd0, hlt}, {11'd0, vecs[i].hlt});
      if (i != vecs.size() - 1) step();
    end

    // halted: frozen at T4 for 20+ clocks, regardless of opcode
    for (int c = 0; c < 22; c++) begin
      step();
      if (c >= 11) opcode = 4'(c);
      #1;
      check("halt_t_state", {6'd0, t_state}, 12'h008);
      check("halt_con", con, 12'h3E3);
      check("halt_hlt", {11'd0, hlt}, 12'h001);
    end

    async_reset = 1'b1;
    #1;
    check("halt_reset_t_state", {6'd0, t_state}, 12'h001);
    check("halt_reset_hlt", {11'd0, hlt}, 12'h000);
    check("halt_reset_con", con, 12'h5E3);
    step();
    async_reset = 1'b0;

    // reset asserted mid-T5 of ADD, between clock edges
    opcode = 4'h1;
    for (int s = 0; s < 4; s++) step();
    check("add_t5_t_state", {6'd0, t_state}, 12'h010);
    check("add_t5_con", con, 12'h2E1);
    #2;
    async_reset = 1'b1;
    #1;
    check("mid_reset_t_state", {6'd0, t_state}, 12'h001);
    check("mid_reset_con", con, 12'h5E3);
    check("mid_reset_hlt", {11'd0, hlt}, 12'h000);
    step();
    async_reset = 1'b0;
    step();
    check("post_release_t2", {6'd0, t_state}, 12'h002);

    // random opcodes against the model
    m_idx         = 1;
    m_halted      = 1'b0;
    halted_cycles = 0;
    for (int n = 0; n < 1000; n++) begin
      op     = 4'($urandom_range(0, 15));
      opcode = op;
      #1;
      check("rand_onehot", 12'($countones(t_state)), 12'd1);
      check_model("rand");
      step();
      if (!m_halted) begin
        if (m_idx == 3 && op == 4'hF) m_halted = 1'b1;
        else                          m_idx    = (m_idx + 1) % 6;
      end
      if (m_halted) halted_cycles++;
      if (halted_cycles > 3) begin
        async_reset = 1'b1;
        #1;
        m_idx         = 0;
        m_halted      = 1'b0;
        halted_cycles = 0;
        check_model("rand_reset");
        #1;
        async_reset = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
